// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - MIPS writeback select, 32x32 register file and commit counter (optional WB_BYPASS_EN)
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] aluOut,
  input  logic [DATA_W-1:0] memOut,
  input  logic              regWrite,
  input  logic              memToReg,
  input  logic [4:0]        regDest,
  input  logic [4:0]        readReg1,
  input  logic [4:0]        readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] writeData,
  output logic [31:0]       wbCount
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [31:0]       wb_count_q;
  logic              commit;

  // Writeback value is always presented so EX forwarding can use it regardless of regWrite
  always_comb begin
    writeData = memToReg ? memOut : aluOut;
  end

  // A write to $zero is discarded entirely, so it neither stores nor counts
  always_comb begin
    commit = regWrite && (regDest != 5'd0);
  end

  // Register array and commit counter; reset wins over a same-edge commit
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wb_count_q <= '0;
    end else if (commit) begin
      regs[regDest] <= writeData;
      wb_count_q    <= wb_count_q + 32'd1;
    end
  end

  // Read port 1: stored value, optionally bypassed from the in-flight commit, $zero forced to 0
  always_comb begin
    readData1 = regs[readReg1];
`ifdef WB_BYPASS_EN
    if (commit && (readReg1 == regDest)) begin
      readData1 = writeData;
    end
`endif
    if (readReg1 == 5'd0) begin
      readData1 = '0;
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    readData2 = regs[readReg2];
`ifdef WB_BYPASS_EN
    if (commit && (readReg2 == regDest)) begin
      readData2 = writeData;
    end
`endif
    if (readReg2 == 5'd0) begin
      readData2 = '0;
    end
  end

  assign wbCount = wb_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - randomized reference-model bench for writeback_regfile
module tb_writeback_regfile;

  logic        clock;
  logic        reset;
  logic [31:0] aluOut;
  logic [31:0] memOut;
  logic        regWrite;
  logic        memToReg;
  logic [4:0]  regDest;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] writeData;
  logic [31:0] wbCount;

  int vectors;
  int miscompares;

  logic [31:0] model_regs [32];
  logic [31:0] model_count;

  writeback_regfile dut (
    .clock     (clock),
    .reset     (reset),
    .aluOut    (aluOut),
    .memOut    (memOut),
    .regWrite  (regWrite),
    .memToReg  (memToReg),
    .regDest   (regDest),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (readData1),
    .readData2 (readData2),
    .writeData (writeData),
    .wbCount   (wbCount)
  );

  // Free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net so the run can never hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // What the ID stage should see for a register index given the current WB inputs
  function automatic logic [31:0] model_read(input logic [4:0] idx);
    logic [31:0] wd;
    wd = memToReg ? memOut : aluOut;
    if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (regWrite && regDest != 5'd0 && idx == regDest) return wd;
`endif
    return model_regs[idx];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_count = 32'd0;
  endfunction

  // One pipeline cycle: drive, check all outputs against the model, then advance the model
  task automatic cycle(input logic rst, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] dest, input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] wd;
    @(negedge clock);
    reset = rst; regWrite = rw; memToReg = m2r; aluOut = alu; memOut = mem;
    regDest = dest; readReg1 = r1; readReg2 = r2;
    #1;
    wd = m2r ? mem : alu;
    check("writeData", writeData, wd);
    check("readData1", readData1, model_read(r1));
    check("readData2", readData2, model_read(r2));
    check("wbCount", wbCount, model_count);
    @(posedge clock);
    if (rst) begin
      model_clear();
    end else if (rw && dest != 5'd0) begin
      model_regs[dest] = wd;
      model_count = model_count + 32'd1;
    end
  endtask

  // Idle cycle with literal expectations for directed scenarios
  task automatic look(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ecnt);
    @(negedge clock);
    reset = 1'b0; regWrite = 1'b0; readReg1 = r1; readReg2 = r2;
    #1;
    check({tag, ".rd1"}, readData1, e1);
    check({tag, ".rd2"}, readData2, e2);
    check({tag, ".cnt"}, wbCount, ecnt);
  endtask

  initial begin
    logic [4:0] d, a, b;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; regWrite = 1'b0; memToReg = 1'b0; aluOut = '0; memOut = '0;
    regDest = '0; readReg1 = '0; readReg2 = '0;
    repeat (2) @(posedge clock);
    model_clear();
    look("reset_state", 5'd5, 5'd31, 32'd0, 32'd0, 32'd0);

    // Test 1: arbitrary writes, then reset clears everything
    cycle(0, 1, 0, 32'hAAAA0005, 32'h0, 5'd5, 5'd0, 5'd0);
    cycle(0, 1, 1, 32'h0, 32'hBBBB0006, 5'd6, 5'd5, 5'd6);
    look("pre_reset", 5'd5, 5'd6, 32'hAAAA0005, 32'hBBBB0006, 32'd2);
    cycle(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);
    look("after_reset", 5'd5, 5'd6, 32'd0, 32'd0, 32'd0);

    // Test 2: ALU writeback then load writeback
    cycle(0, 1, 0, 32'h0000002A, 32'h11111111, 5'd8, 5'd8, 5'd9);
    cycle(0, 1, 1, 32'h22222222, 32'hDEADBEEF, 5'd9, 5'd8, 5'd9);
    look("alu_load", 5'd8, 5'd9, 32'h0000002A, 32'hDEADBEEF, 32'd2);

    // Test 3: write to $zero is discarded
    cycle(0, 1, 0, 32'h12345678, 32'h0, 5'd0, 5'd0, 5'd0);
    look("zero_write", 5'd0, 5'd0, 32'd0, 32'd0, 32'd2);

    // Test 4: same-cycle read of the register being written
    cycle(0, 1, 0, 32'h00000011, 32'h0, 5'd10, 5'd0, 5'd0);
    @(negedge clock);
    reset = 1'b0; regWrite = 1'b1; memToReg = 1'b0; aluOut = 32'h55; regDest = 5'd10;
    readReg1 = 5'd10; readReg2 = 5'd10;
    #1;
`ifdef WB_BYPASS_EN
    check("same_cycle.rd1", readData1, 32'h55);
`else
    check("same_cycle.rd1", readData1, 32'h11);
`endif
    check("same_cycle.rd_match", readData2, model_read(5'd10));
    @(posedge clock);
    model_regs[10] = 32'h55;
    model_count = model_count + 32'd1;
    look("after_edge", 5'd10, 5'd8, 32'h55, 32'h2A, 32'd4);

    // Test 5: reset collides with a commit
    cycle(1, 1, 0, 32'd7, 32'h0, 5'd3, 5'd3, 5'd0);
    look("reset_collide", 5'd3, 5'd10, 32'd0, 32'd0, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      d = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
            $urandom, $urandom, d, a, b);
    end

    // Test 6: counter wrap, with idle cycles holding the count
    @(negedge clock);
    regWrite = 1'b0; reset = 1'b0;
    force dut.wb_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wb_count_q;
    model_count = 32'hFFFFFFFF;
    cycle(0, 0, 0, 32'h1, 32'h2, 5'd4, 5'd4, 5'd0);
    cycle(0, 0, 1, 32'h3, 32'h4, 5'd4, 5'd4, 5'd0);
    cycle(0, 1, 0, 32'hCAFE0001, 32'h0, 5'd4, 5'd4, 5'd0);
    look("wrap", 5'd4, 5'd0, 32'hCAFE0001, 32'd0, 32'd0);
    cycle(0, 0, 0, 32'h0, 32'h0, 5'd7, 5'd4, 5'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
